// File: rtl/dmem_arbiter.sv
// Shares the single DMEM req/ack port between the core (c_*) and an external
// requester (x_*): round-robin arbitration, one access in flight, bus timeout.
module dmem_arbiter #(
    parameter int unsigned address_size = 32,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    c_req,
    input  logic                    c_we,
    input  logic [address_size-1:0] c_addr,
    input  logic [address_size-1:0] c_wdata,
    output logic [address_size-1:0] c_rdata,
    output logic                    c_ack,
    input  logic                    x_req,
    input  logic                    x_we,
    input  logic [address_size-1:0] x_addr,
    input  logic [address_size-1:0] x_wdata,
    output logic [address_size-1:0] x_rdata,
    output logic                    x_ack,
    output logic                    m_req,
    output logic                    m_we,
    output logic [address_size-1:0] m_addr,
    output logic [address_size-1:0] m_wdata,
    input  logic [address_size-1:0] m_rdata,
    input  logic                    m_ack,
    output logic                    err,
    output logic                    stall
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic OWN_C = 1'b0;
    localparam logic OWN_X = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    last_q, last_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    grant_x;
    logic                    done;
    logic [address_size-1:0] done_rdata;
    logic                    m_req_d, m_we_d, c_ack_d, x_ack_d, err_d;
    logic [address_size-1:0] m_addr_d, m_wdata_d, c_rdata_d, x_rdata_d;

    // Core is frozen until its completion pulse arrives.
    assign stall = c_req & ~c_ack;

    // State and registered outputs; reset also aborts any in-flight access.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            owner_q <= OWN_C;
            last_q  <= OWN_X;
            cnt_q   <= '0;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            c_rdata <= '0;
            x_rdata <= '0;
            c_ack   <= 1'b0;
            x_ack   <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            m_req   <= m_req_d;
            m_we    <= m_we_d;
            m_addr  <= m_addr_d;
            m_wdata <= m_wdata_d;
            c_rdata <= c_rdata_d;
            x_rdata <= x_rdata_d;
            c_ack   <= c_ack_d;
            x_ack   <= x_ack_d;
            err     <= err_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        m_req_d    = 1'b0;
        m_we_d     = m_we;
        m_addr_d   = m_addr;
        m_wdata_d  = m_wdata;
        c_rdata_d  = c_rdata;
        x_rdata_d  = x_rdata;
        c_ack_d    = 1'b0;
        x_ack_d    = 1'b0;
        err_d      = 1'b0;
        grant_x    = 1'b0;
        done       = 1'b0;
        done_rdata = '0;

        case (state_q)
            S_IDLE: begin
                if (c_req || x_req) begin
                    // On a tie the requester that did not go last wins.
                    grant_x   = x_req & (~c_req | (last_q == OWN_C));
                    owner_d   = grant_x ? OWN_X : OWN_C;
                    m_we_d    = grant_x ? x_we : c_we;
                    m_addr_d  = grant_x ? x_addr : c_addr;
                    m_wdata_d = grant_x ? x_wdata : c_wdata;
                    cnt_d     = '0;
                    m_req_d   = 1'b1;
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                m_req_d = 1'b1;
                if (m_ack) begin
                    done       = 1'b1;
                    done_rdata = m_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    done       = 1'b1;
                    done_rdata = '0;
                    err_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Completion: only the owner's ack/rdata move; writes keep rdata.
        if (done) begin
            m_req_d = 1'b0;
            state_d = S_RESP;
            if (owner_q == OWN_X) begin
                x_ack_d = 1'b1;
                if (!m_we) x_rdata_d = done_rdata;
            end else begin
                c_ack_d = 1'b1;
                if (!m_we) c_rdata_d = done_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, zero-wait read, contention,
// timeout, requester withdraw, stray ack and reset during an access.
module tb_dmem_arbiter;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        c_req, c_we, x_req, x_we, m_ack;
    logic [31:0] c_addr, c_wdata, x_addr, x_wdata, m_rdata;
    logic [31:0] c_rdata, x_rdata, m_addr, m_wdata;
    logic        c_ack, x_ack, m_req, m_we, err, stall;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter #(.address_size(32), .TIMEOUT(16)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_ack(c_ack),
        .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
        .x_rdata(x_rdata), .x_ack(x_ack),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .err(err), .stall(stall)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int          hi;
        logic        exp_x;
        logic [31:0] exp_xr;
        RESET_N = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h100; c_wdata = 32'h0;
        x_req = 1'b0; x_we = 1'b0; x_addr = 32'h0;   x_wdata = 32'h0;
        m_ack = 1'b0; m_rdata = 32'h0;

        // Reset held two cycles with the core requesting
        tick(); tick();
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_c_ack", 32'(c_ack), 32'd0);
        chk("rst_x_ack", 32'(x_ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_m_addr", m_addr, 32'h0);
        chk("rst_c_rdata", c_rdata, 32'h0);
        chk("rst_x_rdata", x_rdata, 32'h0);
        chk("rst_stall", 32'(stall), 32'd1);
        RESET_N = 1'b1;
        tick();
        chk("rel_m_req", 32'(m_req), 32'd1);
        chk("rel_m_addr", m_addr, 32'h100);
        m_ack = 1'b1; m_rdata = 32'h11;
        tick();
        chk("rel_c_ack", 32'(c_ack), 32'd1);
        chk("rel_c_rdata", c_rdata, 32'h11);
        chk("rel_stall_ack", 32'(stall), 32'd0);
        c_req = 1'b0; m_ack = 1'b0;
        tick();

        // Core read, zero wait states
        c_req = 1'b1; c_addr = 32'h40; c_we = 1'b0;
        tick();
        chk("rd_m_req", 32'(m_req), 32'd1);
        chk("rd_m_addr", m_addr, 32'h40);
        chk("rd_stall_busy", 32'(stall), 32'd1);
        m_ack = 1'b1; m_rdata = 32'hDEADBEEF;
        tick();
        chk("rd_c_ack", 32'(c_ack), 32'd1);
        chk("rd_c_rdata", c_rdata, 32'hDEADBEEF);
        chk("rd_err", 32'(err), 32'd0);
        chk("rd_x_ack", 32'(x_ack), 32'd0);
        c_req = 1'b0; m_ack = 1'b0;
        tick();
        chk("rd_c_ack_pulse", 32'(c_ack), 32'd0);
        chk("rd_c_rdata_hold", c_rdata, 32'hDEADBEEF);

        // Contention: core last served, so X then C alternately
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h80; c_wdata = 32'hC0DE0001;
        x_req = 1'b1; x_we = 1'b0; x_addr = 32'h90;
        exp_xr = 32'h0;
        for (int i = 0; i < 4; i++) begin
            exp_x = (i % 2 == 0);
            tick();
            chk("ct_m_req", 32'(m_req), 32'd1);
            chk("ct_m_addr", m_addr, exp_x ? 32'h90 : 32'h80);
            chk("ct_m_we", 32'(m_we), exp_x ? 32'd0 : 32'd1);
            if (!exp_x) chk("ct_m_wdata", m_wdata, 32'hC0DE0001);
            tick();
            chk("ct_busy2", 32'(m_req), 32'd1);
            m_ack = 1'b1; m_rdata = 32'hA0000000 + 32'(i);
            tick();
            if (exp_x) exp_xr = 32'hA0000000 + 32'(i);
            chk("ct_x_ack", 32'(x_ack), exp_x ? 32'd1 : 32'd0);
            chk("ct_c_ack", 32'(c_ack), exp_x ? 32'd0 : 32'd1);
            chk("ct_x_rdata", x_rdata, exp_xr);
            chk("ct_c_rdata", c_rdata, 32'hDEADBEEF);
            m_ack = 1'b0;
            tick();
            chk("ct_acks_low", 32'({c_ack, x_ack}), 32'd0);
        end
        c_req = 1'b0; x_req = 1'b0;
        tick();

        // Timeout on an external read
        x_req = 1'b1; x_we = 1'b0; x_addr = 32'h200;
        tick();
        hi = m_req ? 1 : 0;
        for (int i = 0; i < 40 && m_req; i++) begin
            tick();
            if (m_req) hi++;
        end
        chk("to_m_req_cycles", 32'(hi), 32'd16);
        chk("to_x_ack", 32'(x_ack), 32'd1);
        chk("to_err", 32'(err), 32'd1);
        chk("to_x_rdata", x_rdata, 32'h0);
        chk("to_c_ack", 32'(c_ack), 32'd0);
        x_req = 1'b0;
        tick();
        chk("to_idle_err", 32'(err), 32'd0);
        chk("to_idle_m_req", 32'(m_req), 32'd0);

        // Stray ack in IDLE
        m_ack = 1'b1;
        tick();
        chk("stray_idle", 32'({m_req, c_ack, x_ack}), 32'd0);
        m_ack = 1'b0;

        // Core write, request withdrawn mid-access
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h300; c_wdata = 32'h12345678;
        tick();
        c_req = 1'b0;
        #1;
        chk("wd_stall_drop", 32'(stall), 32'd0);
        chk("wd_m_addr", m_addr, 32'h300);
        tick();
        chk("wd_busy", 32'(m_req), 32'd1);
        m_ack = 1'b1;
        tick();
        chk("wd_c_ack", 32'(c_ack), 32'd1);
        chk("wd_c_rdata_keep", c_rdata, 32'hDEADBEEF);
        tick();
        chk("stray_resp", 32'({m_req, c_ack, x_ack}), 32'd0);
        tick();
        chk("stray_idle2", 32'({m_req, c_ack, x_ack}), 32'd0);
        m_ack = 1'b0;

        // Reset during BUSY with an ack pending
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h500;
        x_req = 1'b1; x_we = 1'b0; x_addr = 32'h600;
        tick();
        chk("rb_grant_x", m_addr, 32'h600);
        m_ack = 1'b1; RESET_N = 1'b0;
        tick();
        chk("rb_m_req", 32'(m_req), 32'd0);
        chk("rb_acks", 32'({c_ack, x_ack}), 32'd0);
        RESET_N = 1'b1; m_ack = 1'b0;
        tick();
        chk("rb_core_wins", m_addr, 32'h500);
        m_ack = 1'b1; m_rdata = 32'h55AA55AA;
        tick();
        chk("rb_c_ack", 32'(c_ack), 32'd1);
        chk("rb_c_rdata", c_rdata, 32'h55AA55AA);
        m_ack = 1'b0; c_req = 1'b0; x_req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
